// File: rtl/add_seq_arbiter.sv
// Word-serial sequencer and round-robin arbiter for one shared W-bit adder.
// Two requesters submit WORDS*W-bit adds; the granted operation is fed to the
// external adder one word per cycle, LSW first, with the carry chained between
// words in a local register. The full sum and final carry are returned through
// a valid/ready result port.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | arbitrating; req_ready asserted for the granted requester
// RUN    | word k on the shared adder, one word per cycle
// DONE   | result presented, waiting for res_ready

module add_seq_arbiter #(
    parameter int W     = 16,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [W*WORDS-1:0]   a0,
    input  logic [W*WORDS-1:0]   b0,
    input  logic                 cin0,
    input  logic [W*WORDS-1:0]   a1,
    input  logic [W*WORDS-1:0]   b1,
    input  logic                 cin1,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    output logic                 add_cin,
    input  logic [W-1:0]         add_sum,
    input  logic                 add_cout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_id,
    output logic [W*WORDS-1:0]   res_sum,
    output logic                 res_cout,
    output logic                 busy
);

    localparam int OW = W * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            rr_ptr;
    logic [KW-1:0]   k;
    logic            carry_q;
    logic            cin_q;
    logic [OW-1:0]   a_q;
    logic [OW-1:0]   b_q;
    logic [OW-1:0]   sum_q;
    logic            res_id_q;
    logic            res_cout_q;

    logic            req_any;
    logic            grant;
    logic            k_last;

    // Grant selection: a lone requester wins outright, a tie goes to rr_ptr.
    always_comb begin
        req_any = |req_valid;
        grant   = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
        k_last  = (k == K_LAST);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_any)   state_nxt = S_RUN;
            S_RUN:   if (k_last)    state_nxt = S_DONE;
            S_DONE:  if (res_ready) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Output decode: handshake, adder drive and status per state.
    // req_ready is also gated by rst so an asserted reset never shows a grant.
    always_comb begin
        req_ready = 2'b00;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_any && !rst) req_ready[grant] = 1'b1;
            end
            S_RUN: begin
                busy    = 1'b1;
                add_a   = a_q[k*W +: W];
                add_b   = b_q[k*W +: W];
                add_cin = (k == '0) ? cin_q : carry_q;
            end
            S_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture on accept, per-word sum/carry collection while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= 1'b0;
            k          <= '0;
            carry_q    <= 1'b0;
            cin_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            res_id_q   <= 1'b0;
            res_cout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        a_q      <= grant ? a1   : a0;
                        b_q      <= grant ? b1   : b0;
                        cin_q    <= grant ? cin1 : cin0;
                        res_id_q <= grant;
                        rr_ptr   <= ~grant;
                        k        <= '0;
                    end
                end
                S_RUN: begin
                    sum_q[k*W +: W] <= add_sum;
                    carry_q         <= add_cout;
                    if (k_last) begin
                        res_cout_q <= add_cout;
                        k          <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_sum  = sum_q;
    assign res_cout = res_cout_q;
    assign res_id   = res_id_q;

endmodule

// File: tb/tb_add_seq_arbiter.sv
// Randomised self-checking bench for add_seq_arbiter. The shared adder is a
// behavioural model; expected results come from plain wide-integer arithmetic
// and a simple alternating-priority arbitration model.

module tb_add_seq_arbiter;

    localparam int W     = 16;
    localparam int WORDS = 4;
    localparam int OW    = W * WORDS;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [OW-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic            cin0 = 1'b0, cin1 = 1'b0;
    logic [W-1:0]    add_a, add_b, add_sum;
    logic            add_cin, add_cout;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic            res_id;
    logic [OW-1:0]   res_sum;
    logic            res_cout;
    logic            busy;

    int              n_chk  = 0;
    int              n_pass = 0;
    logic            rr_m   = 1'b0;

    add_seq_arbiter #(.W(W), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .cin0      (cin0),
        .a1        (a1),
        .b1        (b1),
        .cin1      (cin1),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .busy      (busy)
    );

    // External ripple-carry adder model.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [1:0] exp_ready(input logic [1:0] v);
        if (v == 2'b00) return 2'b00;
        return 2'b01 << ((v == 2'b11) ? rr_m : v[1]);
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_valid = 2'b00; res_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; rr_m = 1'b0;
    endtask

    // One complete operation: arbitrate, run WORDS cycles, present result,
    // optionally stall res_ready for bp cycles, then hand back to IDLE.
    task automatic run_op(input logic [1:0] vmask, input int bp);
        logic          g, ci;
        logic [OW-1:0] A, B;
        logic [64:0]   expv, part, m;
        @(negedge clk);
        req_valid = vmask;
        #1;
        g = (vmask == 2'b11) ? rr_m : vmask[1];
        chk("ready_onehot", 65'($onehot0(req_ready)), 65'd1);
        chk("req_ready", 65'(req_ready), 65'(exp_ready(vmask)));
        chk("busy_idle", 65'(busy), 65'd0);
        A  = g ? a1 : a0;
        B  = g ? b1 : b0;
        ci = g ? cin1 : cin0;
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        rr_m = ~g;
        for (int n = 0; n < WORDS; n++) begin
            @(negedge clk);
            m    = (65'd1 << (W * n)) - 65'd1;
            part = ({1'b0, A} & m) + ({1'b0, B} & m) + 65'(ci);
            chk("add_a", 65'(add_a), 65'(A[n*W +: W]));
            chk("add_b", 65'(add_b), 65'(B[n*W +: W]));
            chk("add_cin", 65'(add_cin), 65'(part[W*n]));
            chk("run_ctl", 65'({req_ready, busy, res_valid}), 65'(3'b010));
        end
        @(negedge clk);
        expv = {1'b0, A} + {1'b0, B} + 65'(ci);
        chk("res_valid", 65'(res_valid), 65'd1);
        chk("res_sum", 65'(res_sum), 65'(expv[OW-1:0]));
        chk("res_cout", 65'(res_cout), 65'(expv[OW]));
        chk("res_id", 65'(res_id), 65'(g));
        chk("done_ctl", 65'({req_ready, busy}), 65'(3'b001));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", 65'(res_valid), 65'd1);
            chk("bp_sum", 65'({res_cout, res_sum}), expv);
            chk("bp_ctl", 65'({req_ready, busy}), 65'(3'b001));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("valid_drop", 65'(res_valid), 65'd0);
        chk("busy_drop", 65'(busy), 65'd0);
        chk("rearb_ready", 65'(req_ready), 65'(exp_ready(req_valid)));
        req_valid = 2'b00;
    endtask

    initial begin
        logic [1:0] v;
        int         mode;

        #2;
        chk("rst_sum", 65'(res_sum), 65'd0);
        chk("rst_ctl", 65'({req_ready, add_a, add_b, add_cin, res_valid, res_id, res_cout, busy}), 65'd0);
        do_reset();

        // Single op, requester 0.
        a0 = 64'h0000_0000_0000_0001; b0 = '0; cin0 = 1'b0;
        run_op(2'b01, 0);

        // Full-length carry chain, requester 1.
        a1 = 64'hFFFF_FFFF_FFFF_FFFF; b1 = '0; cin1 = 1'b1;
        run_op(2'b10, 0);

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        a0 = 64'h1234_5678_9ABC_DEF0; b0 = 64'h0FED_CBA9_8765_4321; cin0 = 1'b1;
        a1 = 64'h8000_0000_0000_0000; b1 = 64'h8000_0000_0000_0000; cin1 = 1'b0;
        for (int i = 0; i < 4; i++) run_op(2'b11, 0);

        // Backpressure with both requesters pending.
        run_op(2'b11, 10);

        // Mixed-carry pattern.
        a0 = 64'h0001_8000_7FFF_FFFF; b0 = 64'h0000_8000_0000_0001; cin0 = 1'b0;
        run_op(2'b01, 0);

        // Reset in the middle of RUN at k=2.
        a0 = 64'hDEAD_BEEF_CAFE_F00D; b0 = 64'h1111_2222_3333_4444;
        @(negedge clk);
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_sum", 65'(res_sum), 65'd0);
        chk("midrst_ctl", 65'({req_ready, add_a, add_b, add_cin, res_valid, res_id, res_cout, busy}), 65'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rr_m = 1'b0;
        a1 = 64'h7777_0000_FFFF_1234;
        run_op(2'b11, 0);

        // Randomised traffic, including cancelled requests.
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 3);
            a0   = {$urandom, $urandom}; b0 = {$urandom, $urandom}; cin0 = 1'($urandom);
            a1   = {$urandom, $urandom}; b1 = {$urandom, $urandom}; cin1 = 1'($urandom);
            if (mode == 1) begin a0 = '1; a1 = '1; end
            if (mode == 2) begin b0 = ~a0; b1 = ~a1; end
            v = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                req_valid = v;
                #1;
                chk("cancel_ready", 65'(req_ready), 65'(exp_ready(v)));
                #1;
                req_valid = 2'b00;
                @(negedge clk);
                chk("cancel_busy", 65'(busy), 65'd0);
            end
            run_op(v, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
